greyscale_unpacker: RTL and testbench
=====================================

// Module: greyscale_unpacker
// PURPOSE
//  Reads the packed greyscale frame buffer (6 x 8-bit luma per 48-bit word, written by the camera
//  stage) through a BRAM read port and re-emits it as a raster-ordered 1-pixel/cycle stream.
//  Output is valid/ready with hcount/vcount tags; feeds downstream per-pixel processing (e.g. filters).
// PARAMETERS
//  H_ACTIVE      320  pixels per line
//  V_ACTIVE      240  lines per frame
//  PIX_PER_WORD  6    pixels packed per BRAM word
//  PIX_W         8    bits per pixel
//  RD_LATENCY    2    BRAM read latency in cycles (addr -> data), >=1
//  ADDR_W        17   BRAM address width
// PORTS
//  clk_pixel       in   1      pixel clock (74.25 MHz)
//  rst_n_in        in   1      asynchronous, active-low reset
//  start_in        in   1      1-cycle pulse: begin reading one frame
//  rd_addr_out     out  ADDR_W BRAM read address
//  rd_en_out       out  1      BRAM read enable
//  rd_data_in      in   48     BRAM read data, valid RD_LATENCY cycles after rd_en_out
//  pixel_out       out  PIX_W  greyscale pixel
//  h_out           out  11     hcount of pixel_out, 0..H_ACTIVE-1
//  v_out           out  10     vcount of pixel_out, 0..V_ACTIVE-1
//  valid_out       out  1      pixel_out/h_out/v_out valid
//  ready_in        in   1      downstream accepts when valid_out && ready_in
//  last_out        out  1      marks pixel (H_ACTIVE-1, V_ACTIVE-1)
//  busy_out        out  1      frame in progress
//  frame_done_out  out  1      1-cycle pulse the cycle after the last pixel is accepted
// BEHAVIOUR
//  - Reset (async, rst_n_in=0): all outputs 0, state IDLE, word/pixel counters 0, buffers empty.
//  - Word k holds linear pixels 6k..6k+5 (linear = h + H_ACTIVE*v); pixel 6k in [47:40],
//    6k+5 in [7:0]. Words per frame = H_ACTIVE*V_ACTIVE/PIX_PER_WORD = 12800 (addr 0..12799).
//  - FSM: IDLE -> (start_in) PRIME -> STREAM -> (last accepted) DONE -> IDLE.
//    IDLE: rd_en_out=0, valid_out=0. start_in captured only in IDLE; ignored while busy_out=1.
//    PRIME: issue read of word 0; wait RD_LATENCY; load word into shift reg; go STREAM.
//    STREAM: valid_out=1 while shift reg non-empty; on accept shift left by PIX_W, advance h/v.
//    DONE: frame_done_out=1 for exactly one cycle, busy_out drops same cycle, then IDLE.
//  - Prefetch: read of word k+1 issued the cycle word k is loaded into the shift reg (if k<12799);
//    returning data captured into a 1-word holding reg. When 6th pixel of word k is accepted and
//    holding reg is full, next cycle presents pixel 0 of word k+1: no bubbles with ready_in=1.
//  - At most one read outstanding; holding reg never overwritten before consumed.
//  - Latency: start_in -> first valid_out = RD_LATENCY+2 cycles (2+2 = 4 by default).
//  - Handshake: while valid_out=1 && ready_in=0, pixel_out/h_out/v_out/last_out held stable.
//    valid_out never drops without an accept until frame end. ready_in ignored when valid_out=0.
//  - Counters: h wraps H_ACTIVE-1 -> 0 with v+1; after (H_ACTIVE-1, V_ACTIVE-1) both return to 0.
//    Word index saturates at last word; no read past address 12799.
//  - start_in coincident with frame_done_out: ignored (FSM not yet IDLE).
//  - Mid-frame reset: immediate abort, outputs cleared; in-flight BRAM data discarded.
// TESTING
//  1. Word k = {6 bytes (6k+i) mod 256}, start_in, ready_in=1 -> 76800 pixels, pixel n = n mod 256,
//     first valid_out 4 cycles after start, zero gaps, one frame_done_out, h/v correct at each wrap.
//  2. ready_in random 50% -> identical pixel sequence; outputs stable on every stalled cycle.
//  3. Boundaries: pixel 319 -> h=319,v=0; pixel 320 -> h=0,v=1; pixel 76799 last_out=1,
//     h=319, v=239; rd_addr_out never exceeds 12799.
//  4. start_in pulsed at pixel 1000 mid-frame -> ignored; frame completes with exactly 76800 pixels.
//  5. rst_n_in low at pixel 5000 -> all outputs 0 same cycle (async); new start_in -> pixel 0 at h=0,v=0.
//  6. RD_LATENCY=1 and =3 builds, ready_in=1 -> still gap-free stream, first valid at RD_LATENCY+2.

Source files
------------

// File: rtl/greyscale_unpacker.sv
// ---------------------------------------------------------------------------
// greyscale_unpacker
// Reads a packed greyscale frame buffer (PIX_PER_WORD luma samples per BRAM
// word, first pixel in the most significant byte) and re-emits it as a
// raster-ordered, one-pixel-per-cycle valid/ready stream with h/v tags.
//
// Ports
//   clk_pixel      pixel clock
//   rst_n_in       asynchronous active-low reset
//   start_in       1-cycle pulse, begins one frame (only honoured in IDLE)
//   rd_addr_out    BRAM read address (word index)
//   rd_en_out      BRAM read enable
//   rd_data_in     BRAM read data, valid RD_LATENCY cycles after rd_en_out
//   pixel_out      greyscale pixel
//   h_out, v_out   raster position of pixel_out
//   valid_out      pixel_out/h_out/v_out/last_out valid
//   ready_in       downstream accept (transfer when valid_out && ready_in)
//   last_out       marks the final pixel of the frame
//   busy_out       frame in progress
//   frame_done_out 1-cycle pulse the cycle after the last pixel is accepted
// ---------------------------------------------------------------------------
module greyscale_unpacker #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int PIX_PER_WORD = 6,
    parameter int PIX_W        = 8,
    parameter int RD_LATENCY   = 2,
    parameter int ADDR_W       = 17
) (
    input  logic                          clk_pixel,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    output logic [ADDR_W-1:0]             rd_addr_out,
    output logic                          rd_en_out,
    input  logic [PIX_PER_WORD*PIX_W-1:0] rd_data_in,
    output logic [PIX_W-1:0]              pixel_out,
    output logic [10:0]                   h_out,
    output logic [9:0]                    v_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          last_out,
    output logic                          busy_out,
    output logic                          frame_done_out
);

    localparam int                WORD_W    = PIX_PER_WORD * PIX_W;
    localparam int                WORDS     = (H_ACTIVE * V_ACTIVE) / PIX_PER_WORD;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam int                CNT_W     = $clog2(PIX_PER_WORD + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [WORD_W-1:0]     r_shift;
    logic [CNT_W-1:0]      r_cnt;        // pixels still held in r_shift
    logic [WORD_W-1:0]     r_hold;
    logic                  r_hold_full;
    logic [10:0]           r_h;
    logic [9:0]            r_v;
    logic [ADDR_W-1:0]     r_rd_addr;    // address of the most recently requested word
    logic                  r_rd_en;
    logic [RD_LATENCY-1:0] r_rd_pipe;    // tracks the single outstanding read

    logic [RD_LATENCY:0]   w_pipe_in;
    logic                  w_valid;
    logic                  w_accept;
    logic                  w_shift_free;
    logic                  w_data_vld;
    logic                  w_load_hold;
    logic                  w_load_bypass;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_h_end;
    logic                  w_v_end;
    logic                  w_frame_end;

    assign w_pipe_in    = {r_rd_pipe, r_rd_en};
    assign w_data_vld   = r_rd_pipe[RD_LATENCY-1];
    assign w_valid      = (r_cnt != '0);
    assign w_accept     = w_valid && ready_in;
    // The shift register can take a new word if it is empty or its final
    // pixel leaves this cycle; this is what keeps the stream bubble-free.
    assign w_shift_free = (r_cnt == '0) || (w_accept && (r_cnt == CNT_W'(1)));
    // Returning data goes straight into the shift register when it is free
    // and nothing is waiting in the holding register; otherwise it is parked.
    assign w_load_hold   = w_shift_free && r_hold_full;
    assign w_load_bypass = w_shift_free && !r_hold_full && w_data_vld;
    assign w_load        = w_load_hold || w_load_bypass;
    assign w_capture     = w_data_vld && !w_load_bypass;
    assign w_h_end       = (r_h == 11'(H_ACTIVE - 1));
    assign w_v_end       = (r_v == 10'(V_ACTIVE - 1));
    assign w_frame_end   = w_accept && w_h_end && w_v_end;

    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_h         <= '0;
            r_v         <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_pipe   <= '0;
        end else begin
            r_rd_pipe <= w_pipe_in[RD_LATENCY-1:0];
            r_rd_en   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_state   <= S_PRIME;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_h       <= '0;
                        r_v       <= '0;
                    end
                end
                S_PRIME: begin
                    if (w_load) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_frame_end) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rd_addr <= '0;
                end
            endcase

            // Loading word k is the trigger for requesting word k+1, so only
            // one read is ever in flight and the holding register is always
            // drained before its replacement can return.
            if (w_load) begin
                r_shift <= w_load_hold ? r_hold : rd_data_in;
                r_cnt   <= CNT_W'(PIX_PER_WORD);
                if (r_rd_addr != LAST_ADDR) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end else if (w_accept) begin
                r_shift <= r_shift << PIX_W;
                r_cnt   <= r_cnt - CNT_W'(1);
            end

            if (w_load_hold) begin
                r_hold_full <= 1'b0;
            end
            if (w_capture) begin
                r_hold      <= rd_data_in;
                r_hold_full <= 1'b1;
            end

            if (w_accept) begin
                if (w_h_end) begin
                    r_h <= '0;
                    r_v <= w_v_end ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 11'd1;
                end
            end
        end
    end

    assign rd_addr_out    = r_rd_addr;
    assign rd_en_out      = r_rd_en;
    assign pixel_out      = r_shift[WORD_W-1 -: PIX_W];
    assign h_out          = r_h;
    assign v_out          = r_v;
    assign valid_out      = w_valid;
    assign last_out       = w_valid && w_h_end && w_v_end;
    assign busy_out       = (r_state == S_PRIME) || (r_state == S_STREAM);
    assign frame_done_out = (r_state == S_DONE);

endmodule

// File: tb/tb_greyscale_unpacker.sv
// ---------------------------------------------------------------------------
// tb_greyscale_unpacker
// Bench for greyscale_unpacker on a reduced 18x4 frame (12 words). A BRAM
// model returns word k = bytes (6k+i) mod 256. Expected pixels for a whole
// frame are queued when start_in is issued; a monitor pops and compares each
// accepted pixel and checks that stalled outputs hold steady.
// ---------------------------------------------------------------------------
module tb_greyscale_unpacker;

    localparam int H    = 18;
    localparam int V    = 4;
    localparam int PPW  = 6;
    localparam int PW   = 8;
    localparam int L    = 2;
    localparam int AW   = 17;
    localparam int N    = H * V;
    localparam int LAST = N / PPW - 1;

    typedef struct packed {
        logic [7:0]  pix;
        logic [10:0] h;
        logic [9:0]  v;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] rd_addr_out;
    logic          rd_en_out;
    logic [47:0]   rd_data_in;
    logic [7:0]    pixel_out;
    logic [10:0]   h_out;
    logic [9:0]    v_out;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic          last_out;
    logic          busy_out;
    logic          frame_done_out;

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    bit   rand_ready = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    greyscale_unpacker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIX_PER_WORD(PPW), .PIX_W(PW),
        .RD_LATENCY(L), .ADDR_W(AW)
    ) dut (
        .clk_pixel(clk), .rst_n_in(rst_n), .start_in(start_in),
        .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
        .pixel_out(pixel_out), .h_out(h_out), .v_out(v_out),
        .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    // BRAM model: read data appears L cycles after rd_en_out, garbage otherwise.
    logic          q_en   [L];
    logic [AW-1:0] q_addr [L];
    always @(posedge clk) begin
        q_en[0]   <= rd_en_out;
        q_addr[0] <= rd_addr_out;
        for (int i = 1; i < L; i++) begin
            q_en[i]   <= q_en[i-1];
            q_addr[i] <= q_addr[i-1];
        end
    end
    always_comb begin
        rd_data_in = 48'hDEAD_BEEF_0BAD;
        if (q_en[L-1]) begin
            for (int i = 0; i < PPW; i++) begin
                rd_data_in[47-8*i -: 8] = 8'((int'(q_addr[L-1]) * PPW + i) % 256);
            end
        end
    end

    // Downstream ready: constant 1 or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_in = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit   stall_prev;
        exp_t stall_val;
        exp_t cur;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (rd_en_out) begin
                    checks++;
                    if (int'(rd_addr_out) > LAST) begin
                        errors++;
                        $display("FAIL rd_addr_range: got %0d, max %0d", rd_addr_out, LAST);
                    end
                end
                if (valid_out) begin
                    cur = {pixel_out, h_out, v_out, last_out};
                    if (stall_prev) begin
                        checks++;
                        if (cur !== stall_val) begin
                            errors++;
                            $display("FAIL stall_hold: got %h, expected %h", cur, stall_val);
                        end
                    end
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pixel: got pix=%0d h=%0d v=%0d, expected none",
                                 pixel_out, h_out, v_out);
                    end else if (cur !== sb_q[0]) begin
                        errors++;
                        $display("FAIL pixel: got pix=%0d h=%0d v=%0d last=%0b, expected pix=%0d h=%0d v=%0d last=%0b",
                                 pixel_out, h_out, v_out, last_out,
                                 sb_q[0].pix, sb_q[0].h, sb_q[0].v, sb_q[0].last);
                    end
                    if (ready_in) begin
                        if (sb_q.size() > 0) void'(sb_q.pop_front());
                        acc_cnt++;
                    end
                    stall_prev = !ready_in;
                    stall_val  = cur;
                end else begin
                    if (stall_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_dropped: got valid_out=0, expected 1 while stalled");
                    end
                    stall_prev = 1'b0;
                end
                if (frame_done_out) done_cnt++;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_frame();
        for (int n = 0; n < N; n++) begin
            exp_t e;
            e.pix  = 8'(n % 256);
            e.h    = 11'(n % H);
            e.v    = 10'(n / H);
            e.last = (n == N - 1);
            sb_q.push_back(e);
        end
    endtask

    // Issue start_in for one cycle and return cycles until the first valid_out.
    task automatic start_frame(output int lat);
        push_frame();
        start_in = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            start_in = 1'b0;
            lat++;
            if (lat == 1) check("busy_after_start", int'(busy_out), 1);
            if (valid_out) break;
            if (lat > 20) begin
                check("first_valid_timeout", lat, L + 2);
                break;
            end
        end
    endtask

    // Cycles (counting the current one as 1) until frame_done_out is seen.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!frame_done_out) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > limit) begin
                check("frame_done_timeout", cyc, limit);
                break;
            end
        end
    endtask

    task automatic wait_acc(input int base, input int target);
        int cyc;
        cyc = 0;
        while (acc_cnt - base < target) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 2000) begin
                check("accept_timeout", acc_cnt - base, target);
                break;
            end
        end
    endtask

    task automatic outputs_zero(input string name);
        check(name, int'({rd_en_out, rd_addr_out, pixel_out, h_out, v_out, valid_out,
                          last_out, busy_out, frame_done_out} != '0), 0);
    endtask

    initial begin
        int lat, cyc, base, dbase;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outputs_zero("idle_outputs");

        // 1: full frame, ready always high: latency and no gaps.
        dbase = done_cnt;
        base  = acc_cnt;
        start_frame(lat);
        check("t1_latency", lat, L + 2);
        wait_done(N + 10, cyc);
        check("t1_gapless_span", cyc, N + 1);
        check("t1_busy_at_done", int'(busy_out), 0);
        #5;
        check("t1_accepted", acc_cnt - base, N);
        check("t1_queue_empty", sb_q.size(), 0);
        check("t1_done_pulses", done_cnt - dbase, 1);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", int'(frame_done_out), 0);

        // 2: random backpressure.
        rand_ready = 1'b1;
        dbase = done_cnt;
        base  = acc_cnt;
        start_frame(lat);
        wait_done(4 * N + 50, cyc);
        #5;
        check("t2_accepted", acc_cnt - base, N);
        check("t2_queue_empty", sb_q.size(), 0);
        check("t2_done_pulses", done_cnt - dbase, 1);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3: start_in mid-frame is ignored.
        dbase = done_cnt;
        base  = acc_cnt;
        start_frame(lat);
        wait_acc(base, 20);
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        wait_done(2 * N, cyc);
        // start_in during the DONE cycle is ignored too.
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t3_accepted", acc_cnt - base, N);
        check("t3_done_pulses", done_cnt - dbase, 1);
        check("t3_no_restart_busy", int'(busy_out), 0);
        check("t3_no_restart_rd_en", int'(rd_en_out), 0);
        check("t3_queue_empty", sb_q.size(), 0);

        // 4: asynchronous reset mid-frame, then a clean frame.
        base = acc_cnt;
        start_frame(lat);
        wait_acc(base, 30);
        #2;
        rst_n = 1'b0;
        #1;
        outputs_zero("t4_async_reset_outputs");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dbase = done_cnt;
        base  = acc_cnt;
        start_frame(lat);
        check("t4_latency", lat, L + 2);
        check("t4_first_h", int'(h_out), 0);
        check("t4_first_v", int'(v_out), 0);
        wait_done(N + 10, cyc);
        check("t4_gapless_span", cyc, N + 1);
        #5;
        check("t4_accepted", acc_cnt - base, N);
        check("t4_done_pulses", done_cnt - dbase, 1);
        check("t4_queue_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
